ps2_scan_rx: RTL and testbench

PS/2 keyboard receiver and scan-code tracker feeding `Keyboard_Ctrl`. It synchronises and filters the raw `ps2k_clk`/`ps2k_data` lines and deserialises 11-bit device-to-host frames. It resolves make, break (`F0`) and extended (`E0`) prefixes and presents the currently held key as `ps2_byte`/`ps2_state`, the exact pair `Keyboard_Ctrl` consumes.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_frame_rx.sv | 107 ++++++++++
 rtl/ps2_scan_rx.sv | 129 ++++++++++++
 tb/tb_ps2_scan_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, game scan codes and the code-tracker state type.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  // Game keys as consumed by Keyboard_Ctrl; arrows carry the E0 prefix.
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_R     = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } code_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame layer: line synchronisers, clock glitch filter, falling-edge
// detect, 11-bit deserialiser with start/parity/stop checks and idle timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_filt;
  logic                   r_filt_d;
  logic [FW-1:0]          r_fcnt;
  logic [3:0]             r_bitcnt;
  logic [9:0]             r_shift;
  logic [TW-1:0]          r_tcnt;
  logic                   r_rx_valid;
  logic [7:0]             r_rx_data;
  logic                   r_err;

  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic [10:0]            w_frame;
  logic                   w_ok;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_filt_d & ~r_filt;
  // Bits 0..9 are already in the shifter; the stop bit arrives on this edge.
  assign w_frame = {w_dat_s, r_shift};
  assign w_ok    = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
      r_fcnt     <= '0;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tcnt     <= '0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};

      if (w_clk_s != r_filt) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_filt <= w_clk_s;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
      r_filt_d <= r_filt;

      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      if (w_fall) begin
        r_tcnt  <= '0;
        r_shift <= {w_dat_s, r_shift[9:1]};
        if (r_bitcnt == 4'(PS2_FRAME_BITS - 1)) begin
          r_bitcnt   <= '0;
          r_rx_valid <= w_ok;
          r_err      <= ~w_ok;
          r_rx_data  <= w_frame[8:1];
        end else begin
          r_bitcnt <= r_bitcnt + 1'b1;
        end
      end else if (r_bitcnt != '0) begin
        if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          r_bitcnt <= '0;
          r_tcnt   <= '0;
          r_err    <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_data;
  assign o_frame_err = r_err;

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: resolves E0/F0 prefixes and tracks the most
// recently pressed key as the byte/state pair used by Keyboard_Ctrl.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       ps2_ext,
  output logic       ps2_state,
  output logic       make_pulse,
  output logic       frame_err
);

  code_state_t r_st;
  code_state_t w_nxt;
  logic [7:0]  r_byte;
  logic        r_ext;
  logic        r_held;
  logic        r_make;
  logic        r_err;

  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_err;
  logic        w_is_make;
  logic        w_is_brk;
  logic        w_code_ext;
  logic        w_same;
  logic [7:0]  w_byte;
  logic        w_ext;
  logic        w_held;
  logic        w_make;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame (
    .i_clk       (CLK_50M),
    .i_rst_n     (RST_N),
    .i_ps2_clk   (ps2k_clk),
    .i_ps2_data  (ps2k_data),
    .o_rx_valid  (w_valid),
    .o_rx_data   (w_data),
    .o_frame_err (w_err)
  );

  always_comb begin
    w_nxt      = r_st;
    w_is_make  = 1'b0;
    w_is_brk   = 1'b0;
    w_code_ext = 1'b0;
    if (w_err) begin
      w_nxt = ST_IDLE;
    end else if (w_valid) begin
      unique case (r_st)
        ST_IDLE: begin
          if (w_data == PS2_EXT)        w_nxt = ST_EXT;
          else if (w_data == PS2_BREAK) w_nxt = ST_BRK;
          else                          w_is_make = 1'b1;
        end
        ST_EXT: begin
          if (w_data == PS2_BREAK) begin
            w_nxt = ST_EXT_BRK;
          end else begin
            w_is_make  = 1'b1;
            w_code_ext = 1'b1;
            w_nxt      = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_is_brk = 1'b1;
          w_nxt    = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_is_brk   = 1'b1;
          w_code_ext = 1'b1;
          w_nxt      = ST_IDLE;
        end
      endcase
    end

    // A make matching the held key is typematic repeat and leaves outputs alone.
    w_same = r_held && ({w_code_ext, w_data} == {r_ext, r_byte});
    w_byte = r_byte;
    w_ext  = r_ext;
    w_held = r_held;
    w_make = 1'b0;
    if (w_is_make && !w_same) begin
      w_byte = w_data;
      w_ext  = w_code_ext;
      w_held = 1'b1;
      w_make = 1'b1;
    end
    if (w_is_brk && w_same) w_held = 1'b0;
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      r_st   <= ST_IDLE;
      r_byte <= '0;
      r_ext  <= 1'b0;
      r_held <= 1'b0;
      r_make <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_byte <= w_byte;
      r_ext  <= w_ext;
      r_held <= w_held;
      r_make <= w_make;
      r_err  <= w_err;
    end
  end

  assign ps2_byte   = r_byte;
  assign ps2_ext    = r_ext;
  assign ps2_state  = r_held;
  assign make_pulse = r_make;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Directed bench for ps2_scan_rx: make/break/extended sequences, typematic
// repeat, parity error, timeout, clock glitches and mid-frame reset.
module tb_ps2_scan_rx;

  localparam int unsigned HALF = 20;
  localparam int unsigned TMO  = 2000;

  logic       CLK_50M = 1'b0;
  logic       RST_N = 1'b0;
  logic       ps2k_clk = 1'b1;
  logic       ps2k_data = 1'b1;
  logic [7:0] ps2_byte;
  logic       ps2_ext;
  logic       ps2_state;
  logic       make_pulse;
  logic       frame_err;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned n_make = 0;
  int unsigned n_err = 0;
  int unsigned n_viol = 0;
  logic        prev_make = 1'b0;
  logic        prev_err = 1'b0;

  ps2_scan_rx #(
    .SYNC_STAGES (2),
    .FILTER_LEN  (8),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .ps2k_clk   (ps2k_clk),
    .ps2k_data  (ps2k_data),
    .ps2_byte   (ps2_byte),
    .ps2_ext    (ps2_ext),
    .ps2_state  (ps2_state),
    .make_pulse (make_pulse),
    .frame_err  (frame_err)
  );

  always #10 CLK_50M = ~CLK_50M;

  always @(negedge CLK_50M) begin
    if (make_pulse) n_make++;
    if (frame_err) n_err++;
    if (make_pulse && frame_err) n_viol++;
    if (make_pulse && prev_make) n_viol++;
    if (frame_err && prev_err) n_viol++;
    prev_make = make_pulse;
    prev_err  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge CLK_50M);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = bad_par ? (^b) : ~(^b);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int unsigned n, input bit glitch);
    for (int unsigned i = 0; i < n; i++) begin
      ps2k_data = f[i];
      if (glitch) begin
        cyc(6);
        ps2k_clk = 1'b0;
        cyc(4);
        ps2k_clk = 1'b1;
        cyc(10);
      end else begin
        cyc(HALF);
      end
      ps2k_clk = 1'b0;
      cyc(HALF);
      ps2k_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
    send_bits(mk_frame(b, bad_par), 11, glitch);
    ps2k_data = 1'b1;
    cyc(40);
  endtask

  task automatic check_out(input string tag, input logic [7:0] b, input logic e,
                           input logic s, input int unsigned mk, input int unsigned er);
    check({tag, ".byte"}, 32'(ps2_byte), 32'(b));
    check({tag, ".ext"}, 32'(ps2_ext), 32'(e));
    check({tag, ".state"}, 32'(ps2_state), 32'(s));
    check({tag, ".makes"}, n_make, mk);
    check({tag, ".errs"}, n_err, er);
  endtask

  initial begin
    int unsigned waited;
    int unsigned e0;

    cyc(3);
    check_out("reset", 8'h00, 1'b0, 1'b0, 0, 0);
    check("reset.make_pulse", 32'(make_pulse), 32'd0);
    check("reset.frame_err", 32'(frame_err), 32'd0);
    RST_N = 1'b1;
    cyc(20);

    send_byte(8'h1C, 0, 0);
    check_out("make1C", 8'h1C, 1'b0, 1'b1, 1, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    check_out("break1C", 8'h1C, 1'b0, 1'b0, 1, 0);

    send_byte(8'hE0, 0, 0);
    send_byte(8'h6B, 0, 0);
    check_out("makeE06B", 8'h6B, 1'b1, 1'b1, 2, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h6B, 0, 0);
    check_out("breakE06B", 8'h6B, 1'b1, 1'b0, 2, 0);

    send_byte(8'h4D, 0, 0);
    send_byte(8'h4D, 0, 0);
    send_byte(8'h4D, 0, 0);
    check_out("typematic4D", 8'h4D, 1'b0, 1'b1, 3, 0);
    send_byte(8'h2D, 0, 0);
    check_out("replace2D", 8'h2D, 1'b0, 1'b1, 4, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h4D, 0, 0);
    check_out("otherbreak", 8'h2D, 1'b0, 1'b1, 4, 0);

    send_byte(8'hF0, 0, 0);
    send_byte(8'h2D, 0, 0);
    check_out("break2D", 8'h2D, 1'b0, 1'b0, 4, 0);
    send_byte(8'h2D, 1, 0);
    check_out("badparity", 8'h2D, 1'b0, 1'b0, 4, 1);
    send_byte(8'h2D, 0, 0);
    check_out("goodafterbad", 8'h2D, 1'b0, 1'b1, 5, 1);

    // E0 prefix pending, then a truncated frame must time out and drop it.
    send_byte(8'hE0, 0, 0);
    send_bits(mk_frame(8'h74, 0), 5, 0);
    ps2k_data = 1'b1;
    e0 = n_err;
    waited = 0;
    while (waited < TMO + 1000 && n_err == e0) begin
      cyc(1);
      waited++;
    end
    check("timeout.err", n_err, e0 + 1);
    check("timeout.notearly", 32'(waited >= TMO - 100), 32'd1);
    check_out("timeout.hold", 8'h2D, 1'b0, 1'b1, 5, 2);
    send_byte(8'h74, 0, 0);
    check_out("after_timeout74", 8'h74, 1'b0, 1'b1, 6, 2);

    send_byte(8'h1C, 0, 1);
    check_out("glitch1C", 8'h1C, 1'b0, 1'b1, 7, 2);

    check("pulse_shape", n_viol, 0);

    send_bits(mk_frame(8'h6B, 0), 6, 0);
    RST_N = 1'b0;
    #1;
    check("midreset.byte", 32'(ps2_byte), 32'd0);
    check("midreset.ext", 32'(ps2_ext), 32'd0);
    check("midreset.state", 32'(ps2_state), 32'd0);
    check("midreset.make_pulse", 32'(make_pulse), 32'd0);
    check("midreset.frame_err", 32'(frame_err), 32'd0);
    ps2k_data = 1'b1;
    cyc(5);
    RST_N = 1'b1;
    cyc(20);
    send_byte(8'h2D, 0, 0);
    check_out("after_reset2D", 8'h2D, 1'b0, 1'b1, 8, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
